// File: rtl/edabk_dmem_pkg.sv
// Shared constants for the EDABK data memory and the core's store unit.
// The byte-mask constants are lane-0 based; the store unit shifts them left by addr[1:0].
package edabk_dmem_pkg;

    localparam int XLEN       = 32;
    localparam int BYTE_LANES = XLEN / 8;

    localparam logic [BYTE_LANES-1:0] BE_BYTE = 4'b0001;
    localparam logic [BYTE_LANES-1:0] BE_HALF = 4'b0011;
    localparam logic [BYTE_LANES-1:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/edabk_dmem.sv
// Byte-enabled, word-organised data memory for the MEM stage of the CPU_EDABK pipeline.
// Reads are combinational; writes happen on the rising clock edge. Reset only blocks writes.
module edabk_dmem
    import edabk_dmem_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    RD,
    input  logic                    WR,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    output logic [DATA_WIDTH-1:0]   data_out
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] cur_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic                  write_en;

    // Byte offset and bits above the index field are dropped, so accesses wrap modulo DEPTH.
    assign idx      = addr[IDX_W+1:2];
    assign cur_word = mem[idx];

    wire unused_addr_bits = ^{addr[1:0], addr[ADDR_WIDTH-1:IDX_W+2]};

    assign data_out = RD ? cur_word : '0;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign merged_word[8*i +: 8] = byte_en[i] ? data_in[8*i +: 8] : cur_word[8*i +: 8];
    end

    // rst_n is active-high despite its name; it suppresses writes but never clears the array.
    assign write_en = WR && !rst_n && (|byte_en);

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[idx] <= merged_word;
        end
    end

endmodule

// File: tb/tb_edabk_dmem.sv
// Directed bench for edabk_dmem: stimulus pushes expected data_out into a scoreboard queue,
// and a monitor on the falling edge pops and compares.
module tb_edabk_dmem;

    logic        clk;
    logic        rst_n;
    logic        RD;
    logic        WR;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [3:0]  byte_en;
    logic [31:0] data_out;

    typedef struct {
        logic [31:0] exp_data;
        string       name;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        compared   = 0;
    int        mismatched = 0;

    edabk_dmem #(
        .DATA_WIDTH(32),
        .DEPTH     (256),
        .ADDR_WIDTH(32)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RD      (RD),
        .WR      (WR),
        .addr    (addr),
        .data_in (data_in),
        .byte_en (byte_en),
        .data_out(data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle of stimulus, driven just after the rising edge; data_out is settled by the next falling edge.
    task automatic applyStimulus(input logic rst, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] din,
                                 input logic [3:0] be, input logic [31:0] exp_data,
                                 input string name);
        sb_entry_t e;
        @(posedge clk);
        #1;
        rst_n   = rst;
        RD      = rd;
        WR      = wr;
        addr    = a;
        data_in = din;
        byte_en = be;
        e.exp_data = exp_data;
        e.name     = name;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput(input sb_entry_t e, input logic [31:0] actual);
        compared++;
        if (actual !== e.exp_data) begin
            mismatched++;
            $display("[TB] FAIL %s: data_out=%08h expected=%08h", e.name, actual, e.exp_data);
        end
    endtask

    initial begin : monitor
        sb_entry_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput(e, data_out);
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int waited;
        rst_n   = 1'b1;
        RD      = 1'b0;
        WR      = 1'b0;
        addr    = '0;
        data_in = '0;
        byte_en = '0;

        dut.mem[0] = 32'h0000_0000;
        dut.mem[2] = 32'h0000_0001;
        dut.mem[3] = 32'hDEAD_BEEF;
        dut.mem[5] = 32'h1122_3344;
        dut.mem[7] = 32'h0000_0055;

        // Reset state: no read -> zero; reads still work under reset.
        applyStimulus(1, 0, 0, 32'h0C, 32'h0, 4'h0, 32'h0000_0000, "reset_idle");
        applyStimulus(1, 1, 0, 32'h0C, 32'h0, 4'h0, 32'hDEAD_BEEF, "reset_read");

        applyStimulus(0, 1, 0, 32'h0C, 32'h0, 4'h0, 32'hDEAD_BEEF, "read_word3");
        applyStimulus(0, 0, 0, 32'h0C, 32'h0, 4'h0, 32'h0000_0000, "rd_low_zero");

        applyStimulus(0, 0, 1, 32'h14, 32'h00AB_0000, 4'b0100, 32'h0000_0000, "wr_lane2");
        applyStimulus(0, 1, 0, 32'h14, 32'h0, 4'h0, 32'h11AB_3344, "rd_lane2");
        applyStimulus(0, 1, 0, 32'h15, 32'h0, 4'b0001, 32'h11AB_3344, "rd_unmasked");

        applyStimulus(0, 0, 1, 32'h400, 32'hCAFE_F00D, 4'b1111, 32'h0000_0000, "wr_wrap");
        applyStimulus(0, 1, 0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, "rd_wrap");
        applyStimulus(0, 0, 1, 32'h403, 32'h1234_5678, 4'b1111, 32'h0000_0000, "wr_lowbits");
        applyStimulus(0, 1, 0, 32'h0, 32'h0, 4'h0, 32'h1234_5678, "rd_lowbits");
        applyStimulus(0, 1, 0, 32'h800, 32'h0, 4'h0, 32'h1234_5678, "rd_wrap_hi");

        applyStimulus(0, 1, 1, 32'h08, 32'h0000_0002, 4'b1111, 32'h0000_0001, "rdwr_old");
        applyStimulus(0, 1, 0, 32'h08, 32'h0, 4'h0, 32'h0000_0002, "rdwr_new");

        applyStimulus(1, 0, 1, 32'h1C, 32'h0, 4'b1111, 32'h0000_0000, "wr_in_reset");
        applyStimulus(0, 1, 0, 32'h1C, 32'h0, 4'h0, 32'h0000_0055, "rd_after_reset");

        applyStimulus(0, 0, 1, 32'h1C, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0000, "wr_be_zero");
        applyStimulus(0, 1, 0, 32'h1C, 32'h0, 4'h0, 32'h0000_0055, "rd_be_zero");

        applyStimulus(0, 0, 1, 32'h1C, 32'h0000_BBAA, 4'b0011, 32'h0000_0000, "wr_half");
        applyStimulus(0, 1, 0, 32'h1C, 32'h0, 4'h0, 32'h0000_BBAA, "rd_half");

        applyStimulus(0, 0, 1, 32'h0B, 32'hAA00_0000, 4'b1000, 32'h0000_0000, "wr_lane3");
        applyStimulus(0, 1, 0, 32'h08, 32'h0, 4'h0, 32'hAA00_0002, "rd_lane3");

        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0000_0000, "idle_end");

        waited = 0;
        while (sb_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (sb_q.size() > 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
